// File: rtl/rs_branch_ooo_pkg.sv
// Shared defaults for the parametrised branch reservation station.
// Latency: n/a (constants only).
// Backpressure: n/a.
package rs_branch_ooo_pkg;

    // Default geometry of the station; modules take these as parameter defaults.
    localparam int DEF_DEPTH   = 4;
    localparam int DEF_SEL_W   = 2;
    localparam int DEF_NUM_CDB = 2;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_TAG_W   = 5;
    localparam int DEF_OP_W    = 6;

    // An all-zeros rename tag means the operand value is already present
    // (tagFree). Slots widen this to their own TAG_W.
    localparam logic TAG_FREE_BIT = 1'b0;

endpackage

// File: rtl/rs_branch_slot.sv
// One branch RS entry: holds op, operands, offset and PC; snoops every CDB channel.
// Latency: a broadcast captured at the edge ending its cycle; ready reflects same-cycle broadcasts.
// Backpressure: none of its own; parent drives load/clear, and rdy=0 freezes the entry.
module rs_branch_slot
    import rs_branch_ooo_pkg::*;
#(
    parameter int NUM_CDB = DEF_NUM_CDB,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int TAG_W   = DEF_TAG_W,
    parameter int OP_W    = DEF_OP_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      flush,
    input  logic                      load,
    input  logic                      clear,
    input  logic [OP_W-1:0]           in_op,
    input  logic [TAG_W-1:0]          in_tag1,
    input  logic [DATA_W-1:0]         in_data1,
    input  logic [TAG_W-1:0]          in_tag2,
    input  logic [DATA_W-1:0]         in_data2,
    input  logic [DATA_W-1:0]         in_offset,
    input  logic [ADDR_W-1:0]         in_pc,
    input  logic [NUM_CDB-1:0]        cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
    input  logic [NUM_CDB*DATA_W-1:0] cdb_data,
    output logic                      busy,
    output logic                      ready,
    output logic [OP_W-1:0]           out_op,
    output logic [DATA_W-1:0]         out_data1,
    output logic [DATA_W-1:0]         out_data2,
    output logic [DATA_W-1:0]         out_offset,
    output logic [ADDR_W-1:0]         out_pc
);

    localparam logic [TAG_W-1:0] TAG_FREE = {TAG_W{TAG_FREE_BIT}};

    logic              busy_q,   busy_d;
    logic [OP_W-1:0]   op_q,     op_d;
    logic [TAG_W-1:0]  tag1_q,   tag1_d;
    logic [DATA_W-1:0] data1_q,  data1_d;
    logic [TAG_W-1:0]  tag2_q,   tag2_d;
    logic [DATA_W-1:0] data2_q,  data2_d;
    logic [DATA_W-1:0] offset_q, offset_d;
    logic [ADDR_W-1:0] pc_q,     pc_d;

    logic [TAG_W-1:0]  nxt_tag1, nxt_tag2, ld_tag1, ld_tag2;
    logic [DATA_W-1:0] nxt_data1, nxt_data2, ld_data1, ld_data2;

    // Resolve one operand against all channels; scanning downwards lets the lowest channel win.
    function automatic logic [TAG_W+DATA_W-1:0] wake(
        input logic [TAG_W-1:0]          tag,
        input logic [DATA_W-1:0]         data,
        input logic [NUM_CDB-1:0]        vld,
        input logic [NUM_CDB*TAG_W-1:0]  tags,
        input logic [NUM_CDB*DATA_W-1:0] datas
    );
        logic [TAG_W-1:0]  t;
        logic [DATA_W-1:0] d;
        t = tag;
        d = data;
        for (int k = NUM_CDB - 1; k >= 0; k--) begin
            if (tag != TAG_FREE && vld[k] && tags[k*TAG_W +: TAG_W] == tag) begin
                t = TAG_FREE;
                d = datas[k*DATA_W +: DATA_W];
            end
        end
        return {t, d};
    endfunction

    // Wakeup of held operands and of the operands arriving with an allocation.
    always_comb begin
        {nxt_tag1, nxt_data1} = wake(tag1_q,   data1_q,  cdb_valid, cdb_tag, cdb_data);
        {nxt_tag2, nxt_data2} = wake(tag2_q,   data2_q,  cdb_valid, cdb_tag, cdb_data);
        {ld_tag1,  ld_data1}  = wake(in_tag1,  in_data1, cdb_valid, cdb_tag, cdb_data);
        {ld_tag2,  ld_data2}  = wake(in_tag2,  in_data2, cdb_valid, cdb_tag, cdb_data);
    end

    // Next entry state: flush beats load beats clear beats plain wakeup.
    always_comb begin
        busy_d   = busy_q;
        op_d     = op_q;
        tag1_d   = tag1_q;
        data1_d  = data1_q;
        tag2_d   = tag2_q;
        data2_d  = data2_q;
        offset_d = offset_q;
        pc_d     = pc_q;
        if (rdy) begin
            if (flush) begin
                busy_d = 1'b0;
            end else if (load) begin
                busy_d   = 1'b1;
                op_d     = in_op;
                tag1_d   = ld_tag1;
                data1_d  = ld_data1;
                tag2_d   = ld_tag2;
                data2_d  = ld_data2;
                offset_d = in_offset;
                pc_d     = in_pc;
            end else if (clear) begin
                busy_d = 1'b0;
            end else if (busy_q) begin
                tag1_d  = nxt_tag1;
                data1_d = nxt_data1;
                tag2_d  = nxt_tag2;
                data2_d = nxt_data2;
            end
        end
    end

    // Entry registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q   <= 1'b0;
            op_q     <= '0;
            tag1_q   <= '0;
            data1_q  <= '0;
            tag2_q   <= '0;
            data2_q  <= '0;
            offset_q <= '0;
            pc_q     <= '0;
        end else begin
            busy_q   <= busy_d;
            op_q     <= op_d;
            tag1_q   <= tag1_d;
            data1_q  <= data1_d;
            tag2_q   <= tag2_d;
            data2_q  <= data2_d;
            offset_q <= offset_d;
            pc_q     <= pc_d;
        end
    end

    assign busy       = busy_q;
    assign ready      = busy_q && nxt_tag1 == TAG_FREE && nxt_tag2 == TAG_FREE;
    assign out_op     = op_q;
    assign out_data1  = nxt_data1;
    assign out_data2  = nxt_data2;
    assign out_offset = offset_q;
    assign out_pc     = pc_q;

endmodule

// File: rtl/rs_branch_ooo.sv
// Branch reservation station: holds branch ops until operands arrive, issues oldest ready first.
// Latency: ready-at-alloc op issues 2 cycles later; last-operand CDB wakeup issues next cycle.
// Backpressure: full stops dispatch; issue register holds while issue_valid && !issue_ready.
module rs_branch_ooo
    import rs_branch_ooo_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int SEL_W   = DEF_SEL_W,
    parameter int NUM_CDB = DEF_NUM_CDB,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int TAG_W   = DEF_TAG_W,
    parameter int OP_W    = DEF_OP_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      flush,
    input  logic                      alloc_valid,
    input  logic [OP_W-1:0]           alloc_op,
    input  logic [TAG_W-1:0]          alloc_tag1,
    input  logic [TAG_W-1:0]          alloc_tag2,
    input  logic [DATA_W-1:0]         alloc_data1,
    input  logic [DATA_W-1:0]         alloc_data2,
    input  logic [DATA_W-1:0]         alloc_offset,
    input  logic [ADDR_W-1:0]         alloc_pc,
    output logic                      full,
    input  logic [NUM_CDB-1:0]        cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
    input  logic [NUM_CDB*DATA_W-1:0] cdb_data,
    output logic                      issue_valid,
    input  logic                      issue_ready,
    output logic [DATA_W-1:0]         issue_src1,
    output logic [DATA_W-1:0]         issue_src2,
    output logic [ADDR_W-1:0]         issue_pc,
    output logic [OP_W-1:0]           issue_op,
    output logic [DATA_W-1:0]         issue_offset
);

    logic [DEPTH-1:0]  busy, ready, load_vec, clear_vec, oldest_vec;
    logic [OP_W-1:0]   s_op     [DEPTH];
    logic [DATA_W-1:0] s_data1  [DEPTH];
    logic [DATA_W-1:0] s_data2  [DEPTH];
    logic [DATA_W-1:0] s_offset [DEPTH];
    logic [ADDR_W-1:0] s_pc     [DEPTH];

    // older_q[j][i] set means entry j was allocated before entry i.
    logic [DEPTH-1:0]  older_q [DEPTH];
    logic [DEPTH-1:0]  older_d [DEPTH];

    logic [SEL_W-1:0]  alloc_idx, sel_idx;
    logic              sel_hit, sel_en, alloc_fire, issue_fire;

    logic              issue_valid_q,  issue_valid_d;
    logic [DATA_W-1:0] issue_src1_q,   issue_src1_d;
    logic [DATA_W-1:0] issue_src2_q,   issue_src2_d;
    logic [ADDR_W-1:0] issue_pc_q,     issue_pc_d;
    logic [OP_W-1:0]   issue_op_q,     issue_op_d;
    logic [DATA_W-1:0] issue_offset_q, issue_offset_d;

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        rs_branch_slot #(
            .NUM_CDB (NUM_CDB),
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .TAG_W   (TAG_W),
            .OP_W    (OP_W)
        ) u_slot (
            .clk        (clk),
            .rst        (rst),
            .rdy        (rdy),
            .flush      (flush),
            .load       (load_vec[g]),
            .clear      (clear_vec[g]),
            .in_op      (alloc_op),
            .in_tag1    (alloc_tag1),
            .in_data1   (alloc_data1),
            .in_tag2    (alloc_tag2),
            .in_data2   (alloc_data2),
            .in_offset  (alloc_offset),
            .in_pc      (alloc_pc),
            .cdb_valid  (cdb_valid),
            .cdb_tag    (cdb_tag),
            .cdb_data   (cdb_data),
            .busy       (busy[g]),
            .ready      (ready[g]),
            .out_op     (s_op[g]),
            .out_data1  (s_data1[g]),
            .out_data2  (s_data2[g]),
            .out_offset (s_offset[g]),
            .out_pc     (s_pc[g])
        );
    end

    // full comes from registered busy only, so a slot freed this cycle is reusable next cycle.
    assign full = &busy;

    // Lowest-index free slot and oldest ready slot, plus the per-slot load/clear strobes.
    always_comb begin
        alloc_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!busy[i]) alloc_idx = SEL_W'(i);
        end
        for (int i = 0; i < DEPTH; i++) begin
            oldest_vec[i] = ready[i];
            for (int j = 0; j < DEPTH; j++) begin
                if (ready[j] && older_q[j][i]) oldest_vec[i] = 1'b0;
            end
        end
        sel_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (oldest_vec[i]) sel_idx = SEL_W'(i);
        end
        sel_hit    = |ready;
        sel_en     = !issue_valid_q || issue_ready;
        alloc_fire = rdy && !flush && alloc_valid && !full;
        issue_fire = rdy && !flush && sel_en && sel_hit;
        for (int i = 0; i < DEPTH; i++) begin
            load_vec[i]  = alloc_fire && alloc_idx == SEL_W'(i);
            clear_vec[i] = issue_fire && sel_idx == SEL_W'(i);
        end
    end

    // Age matrix: issued entry drops out first, then the new entry becomes younger than survivors.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) older_d[i] = older_q[i];
        if (rdy) begin
            if (flush) begin
                for (int i = 0; i < DEPTH; i++) older_d[i] = '0;
            end else begin
                if (issue_fire) begin
                    older_d[sel_idx] = '0;
                    for (int j = 0; j < DEPTH; j++) older_d[j][sel_idx] = 1'b0;
                end
                if (alloc_fire) begin
                    for (int j = 0; j < DEPTH; j++) begin
                        older_d[j][alloc_idx] = (SEL_W'(j) != alloc_idx) && busy[j] && !clear_vec[j];
                    end
                    older_d[alloc_idx] = '0;
                end
            end
        end
    end

    // Issue register: loads the selected entry when empty or being accepted, otherwise holds.
    always_comb begin
        issue_valid_d  = issue_valid_q;
        issue_src1_d   = issue_src1_q;
        issue_src2_d   = issue_src2_q;
        issue_pc_d     = issue_pc_q;
        issue_op_d     = issue_op_q;
        issue_offset_d = issue_offset_q;
        if (rdy) begin
            if (flush) begin
                issue_valid_d  = 1'b0;
                issue_src1_d   = '0;
                issue_src2_d   = '0;
                issue_pc_d     = '0;
                issue_op_d     = '0;
                issue_offset_d = '0;
            end else if (sel_en) begin
                issue_valid_d = sel_hit;
                if (sel_hit) begin
                    issue_src1_d   = s_data1[sel_idx];
                    issue_src2_d   = s_data2[sel_idx];
                    issue_pc_d     = s_pc[sel_idx];
                    issue_op_d     = s_op[sel_idx];
                    issue_offset_d = s_offset[sel_idx];
                end
            end
        end
    end

    // Age matrix and issue register state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) older_q[i] <= '0;
            issue_valid_q  <= 1'b0;
            issue_src1_q   <= '0;
            issue_src2_q   <= '0;
            issue_pc_q     <= '0;
            issue_op_q     <= '0;
            issue_offset_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) older_q[i] <= older_d[i];
            issue_valid_q  <= issue_valid_d;
            issue_src1_q   <= issue_src1_d;
            issue_src2_q   <= issue_src2_d;
            issue_pc_q     <= issue_pc_d;
            issue_op_q     <= issue_op_d;
            issue_offset_q <= issue_offset_d;
        end
    end

    assign issue_valid  = issue_valid_q;
    assign issue_src1   = issue_src1_q;
    assign issue_src2   = issue_src2_q;
    assign issue_pc     = issue_pc_q;
    assign issue_op     = issue_op_q;
    assign issue_offset = issue_offset_q;

endmodule
